// File: rtl/raycast_pkg.sv
// raycast_pkg: shared types and screen geometry for the ray-cast render pipeline.
package raycast_pkg;
    typedef enum logic [1:0] {LAUNCH, RENDER, WAIT_SWAP} t_sched_state;
    localparam int DEFAULT_SCREEN_WIDTH = 320;
    localparam int DEFAULT_SCREEN_HEIGHT = 180;
    localparam int FB_DEPTH = DEFAULT_SCREEN_WIDTH * DEFAULT_SCREEN_HEIGHT;
endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// frame_buffer_scheduler_if: ray pixel stream in, frame buffer write port and status out.
interface frame_buffer_scheduler_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int PIXEL_WIDTH = 16
);
    logic                   frame_start_in;
    logic                   ray_valid_in;
    logic [ADDR_WIDTH-1:0]  ray_address_in;
    logic [PIXEL_WIDTH-1:0] ray_pixel_in;
    logic                   ray_last_pixel_in;
    logic                   sweep_start_out;
    logic                   sweep_busy_out;
    logic                   wr_en_out;
    logic [ADDR_WIDTH:0]    wr_addr_out;
    logic [PIXEL_WIDTH-1:0] wr_data_out;
    logic                   rd_bank_out;
    logic [7:0]             frames_missed_out;
    logic                   addr_error_out;
    modport master (
        output frame_start_in, ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
        input  sweep_start_out, sweep_busy_out, wr_en_out, wr_addr_out, wr_data_out,
               rd_bank_out, frames_missed_out, addr_error_out
    );
    modport slave (
        input  frame_start_in, ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
        output sweep_start_out, sweep_busy_out, wr_en_out, wr_addr_out, wr_data_out,
               rd_bank_out, frames_missed_out, addr_error_out
    );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler: launches ray sweeps, steers pixel writes into the back bank
// and swaps banks only on a display frame boundary after the sweep completes.
module frame_buffer_scheduler
    import raycast_pkg::*;
#(
    parameter int SCREEN_WIDTH = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int ADDR_WIDTH = 16,
    parameter int PIXEL_WIDTH = 16
) (
    input logic pixel_clk_in,
    input logic rst_in,
    frame_buffer_scheduler_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(SCREEN_WIDTH * SCREEN_HEIGHT);
    t_sched_state state, nxt;
    logic                   start_q, wr_en_q, bank_q, err_q;
    logic [ADDR_WIDTH:0]    wr_addr_q;
    logic [PIXEL_WIDTH-1:0] wr_data_q;
    logic [7:0]             missed_q;
    logic addr_ok, wr_go, err_hit, miss_hit, swap;
    always_comb begin
        addr_ok = {1'b0, bus.ray_address_in} < DEPTH;
        wr_go = state == RENDER && bus.ray_valid_in && addr_ok;
        err_hit = bus.ray_valid_in && !wr_go;
        miss_hit = state == RENDER && bus.frame_start_in && missed_q != 8'hff;
        swap = state == WAIT_SWAP && bus.frame_start_in;
        nxt = state == LAUNCH ? RENDER :
              state == RENDER ? (bus.ray_valid_in && bus.ray_last_pixel_in ? WAIT_SWAP : RENDER) :
              swap ? LAUNCH : WAIT_SWAP;
    end
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) state <= LAUNCH;
        else state <= nxt;
    end
    // Writes always target the bank not being displayed.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            start_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bank_q <= 1'b0;
            missed_q <= '0;
            err_q <= 1'b0;
        end else begin
            start_q <= state == LAUNCH;
            wr_en_q <= wr_go;
            if (wr_go) begin
                wr_addr_q <= {~bank_q, bus.ray_address_in};
                wr_data_q <= bus.ray_pixel_in;
            end
            bank_q <= bank_q ^ swap;
            missed_q <= missed_q + 8'(miss_hit);
            err_q <= err_q | err_hit;
        end
    end
    assign bus.sweep_start_out = start_q;
    assign bus.sweep_busy_out = state == RENDER;
    assign bus.wr_en_out = wr_en_q;
    assign bus.wr_addr_out = wr_addr_q;
    assign bus.wr_data_out = wr_data_q;
    assign bus.rd_bank_out = bank_q;
    assign bus.frames_missed_out = missed_q;
    assign bus.addr_error_out = err_q;
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb_frame_buffer_scheduler: table vectors, directed sequences and random stimulus
// checked against a cycle-level behavioural model of the scheduler.
module tb_frame_buffer_scheduler;
    import raycast_pkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    frame_buffer_scheduler_if #(.ADDR_WIDTH(16), .PIXEL_WIDTH(16)) bus();
    frame_buffer_scheduler #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(180), .ADDR_WIDTH(16), .PIXEL_WIDTH(16))
        dut (.pixel_clk_in(clk), .rst_in(rst), .bus(bus));
    typedef struct {
        logic f, v, l;
        logic [15:0] a;
        logic start, busy, wr, msb, bank, err;
        logic [7:0] miss;
    } row_t;
    row_t rows[11];
    int vectors = 0, errors = 0, cyc = 0;
    int nwr = 0, nwr_hi = 0, nstart = 0;
    int m_phase;
    logic m_bank, m_err, m_start, m_wr;
    logic [7:0] m_miss;
    logic [16:0] m_addr;
    logic [15:0] m_data;
    logic [45:0] got, exp_v;
    task automatic model(input logic r, f, v, l, input logic [15:0] a, p);
        if (r) begin
            m_phase = 0; m_bank = 0; m_miss = 0; m_err = 0;
            m_start = 0; m_wr = 0; m_addr = 0; m_data = 0;
        end else begin
            m_start = m_phase == 0;
            m_wr = m_phase == 1 && v && a < FB_DEPTH;
            if (m_wr) begin
                m_addr = {~m_bank, a};
                m_data = p;
            end
            if (v && !m_wr) m_err = 1;
            if (m_phase == 1 && f && m_miss < 255) m_miss = m_miss + 1;
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1) begin
                if (v && l) m_phase = 2;
            end else if (f) begin
                m_bank = ~m_bank;
                m_phase = 0;
            end
        end
    endtask
    task automatic check(input string name, input int g, input int e);
        vectors++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, g, e);
        end
    endtask
    task automatic step(input logic r, f, v, l, input logic [15:0] a, p);
        rst = r;
        bus.frame_start_in = f;
        bus.ray_valid_in = v;
        bus.ray_last_pixel_in = l;
        bus.ray_address_in = a;
        bus.ray_pixel_in = p;
        @(posedge clk);
        model(r, f, v, l, a, p);
        #1;
        cyc++;
        got = {bus.sweep_start_out, bus.sweep_busy_out, bus.wr_en_out, bus.wr_addr_out, bus.wr_data_out,
               bus.rd_bank_out, bus.frames_missed_out, bus.addr_error_out};
        exp_v = {m_start, m_phase == 1, m_wr, m_addr, m_data, m_bank, m_miss, m_err};
        vectors++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL model cyc=%0d got=%h expected=%h", cyc, got, exp_v);
        end
        if (bus.wr_en_out) begin
            nwr++;
            if (bus.wr_addr_out[16]) nwr_hi++;
        end
        if (bus.sweep_start_out) nstart++;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'd0, 16'd0);
    endtask
    initial begin
        int w0, h0, s0;
        logic [13:0] tg, te;
        rows[0]  = '{0, 0, 0, 16'd0,     1, 1, 0, 0, 0, 0, 8'd0};
        rows[1]  = '{0, 1, 0, 16'd57599, 0, 1, 1, 1, 0, 0, 8'd0};
        rows[2]  = '{0, 1, 0, 16'd57600, 0, 1, 0, 0, 0, 1, 8'd0};
        rows[3]  = '{1, 0, 0, 16'd0,     0, 1, 0, 0, 0, 1, 8'd1};
        rows[4]  = '{1, 1, 0, 16'd5,     0, 1, 1, 1, 0, 1, 8'd2};
        rows[5]  = '{0, 1, 0, 16'd65535, 0, 1, 0, 0, 0, 1, 8'd2};
        rows[6]  = '{1, 1, 1, 16'd100,   0, 0, 1, 1, 0, 1, 8'd3};
        rows[7]  = '{0, 1, 0, 16'd3,     0, 0, 0, 0, 0, 1, 8'd3};
        rows[8]  = '{1, 0, 0, 16'd0,     0, 0, 0, 0, 1, 1, 8'd3};
        rows[9]  = '{0, 0, 0, 16'd0,     1, 1, 0, 0, 1, 1, 8'd3};
        rows[10] = '{0, 1, 0, 16'd7,     0, 1, 1, 0, 1, 1, 8'd3};
        step(1, 0, 0, 0, 16'd0, 16'd0);
        step(1, 0, 0, 0, 16'd0, 16'd0);
        check("reset_outputs_zero", int'(got == 46'd0), 1);
        for (int i = 0; i < 11; i++) begin
            step(0, rows[i].f, rows[i].v, rows[i].l, rows[i].a, 16'(i * 3 + 1));
            tg = {bus.sweep_start_out, bus.sweep_busy_out, bus.wr_en_out, bus.wr_en_out & bus.wr_addr_out[16],
                  bus.rd_bank_out, bus.addr_error_out, bus.frames_missed_out};
            te = {rows[i].start, rows[i].busy, rows[i].wr, rows[i].msb, rows[i].bank, rows[i].err, rows[i].miss};
            check($sformatf("table_row%0d", i), int'(tg), int'(te));
        end
        step(1, 0, 0, 0, 16'd0, 16'd0);
        s0 = nstart;
        idle(40);
        check("idle_start_pulses", nstart - s0, 1);
        step(1, 0, 0, 0, 16'd0, 16'd0);
        idle(1);
        w0 = nwr;
        h0 = nwr_hi;
        for (int i = 0; i < FB_DEPTH; i++)
            step(0, 0, 1, i == FB_DEPTH - 1, 16'(i), 16'(i) ^ 16'hA5A5);
        idle(1);
        check("sweep_writes", nwr - w0, FB_DEPTH);
        check("sweep_writes_bank1", nwr_hi - h0, FB_DEPTH);
        check("sweep_wait_not_busy", int'(bus.sweep_busy_out), 0);
        check("sweep_no_err", int'(bus.addr_error_out), 0);
        step(0, 1, 0, 0, 16'd0, 16'd0);
        check("swap_bank", int'(bus.rd_bank_out), 1);
        check("swap_no_start_yet", int'(bus.sweep_start_out), 0);
        idle(1);
        check("swap_start", int'(bus.sweep_start_out), 1);
        step(0, 0, 1, 0, 16'd42, 16'h1234);
        check("second_sweep_addr", int'(bus.wr_addr_out), 42);
        step(1, 0, 0, 0, 16'd0, 16'd0);
        idle(1);
        for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 16'd0, 16'd0);
        check("missed_saturate", int'(bus.frames_missed_out), 255);
        check("missed_no_swap", int'(bus.rd_bank_out), 0);
        step(1, 0, 0, 0, 16'd0, 16'd0);
        idle(1);
        for (int i = 0; i < 1000; i++) step(0, 0, 1, 0, 16'(i), 16'(i));
        step(1, 0, 0, 0, 16'd0, 16'd0);
        check("midreset_outputs_zero", int'(got == 46'd0), 1);
        idle(1);
        check("midreset_start", int'(bus.sweep_start_out), 1);
        step(0, 0, 1, 0, 16'd9, 16'd9);
        check("midreset_bank1_write", int'(bus.wr_addr_out), 32'h10009);
        step(1, 0, 0, 0, 16'd0, 16'd0);
        for (int i = 0; i < 4000; i++) begin
            logic r, f, v, l;
            logic [15:0] a;
            r = $urandom % 1500 == 0;
            f = $urandom % 40 == 0;
            v = $urandom % 4 != 0;
            l = v && $urandom % 150 == 0;
            a = $urandom % 16 == 0 ? 16'(FB_DEPTH + $urandom % 7936) : 16'($urandom % FB_DEPTH);
            step(r, f, v, l, a, 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Sequences the ray-cast render loop around a double-buffered frame buffer.
- Pulses the ray sweep start and steers flattened pixel writes (address/pixel/last-pixel stream) into the back bank.
- Swaps front/back banks only at a display frame boundary, after the sweep has completed.
- Sits between the flattening stage and the frame buffer BRAM; the video readout uses rd_bank_out to pick the front bank.

Parameters:
- SCREEN_WIDTH, 320, rendered columns.
- SCREEN_HEIGHT, 180, rendered rows.
- ADDR_WIDTH, 16, width of the per-bank pixel address.
- PIXEL_WIDTH, 16, pixel data width.

Ports:
- pixel_clk_in  input  1  sole clock.
- rst_in  input  1  synchronous, active-high reset.
- frame_start_in  input  1  one-cycle pulse from video timing at the start of each display frame.
- ray_valid_in  input  1  qualifies the ray_* inputs this cycle.
- ray_address_in  input  ADDR_WIDTH  flattened pixel address, hcount + vcount*SCREEN_WIDTH.
- ray_pixel_in  input  PIXEL_WIDTH  pixel value.
- ray_last_pixel_in  input  1  final pixel of the sweep; valid only with ray_valid_in.
- sweep_start_out  output  1  one-cycle pulse; starts a new ray sweep.
- sweep_busy_out  output  1  high while the sweep is in progress (RENDER).
- wr_en_out  output  1  frame buffer write enable.
- wr_addr_out  output  ADDR_WIDTH+1  {back bank, pixel address}.
- wr_data_out  output  PIXEL_WIDTH  write data.
- rd_bank_out  output  1  bank the video readout must display.
- frames_missed_out  output  8  saturating count of frame_start_in pulses seen during RENDER.
- addr_error_out  output  1  sticky flag: out-of-range address or stray valid.

Behaviour:
- Reset values: state=LAUNCH, rd_bank_out=0, back bank=1, all pulses/enables 0, wr_addr_out=0, wr_data_out=0, frames_missed_out=0, addr_error_out=0.
- Reset mid-sweep discards all progress; the next sweep starts in bank 1.
- FB_DEPTH = SCREEN_WIDTH*SCREEN_HEIGHT = 57600.
- LAUNCH:
  - sweep_start_out=1 for exactly this cycle.
  - Next state RENDER.
- RENDER:
  - sweep_busy_out=1.
  - On ray_valid_in, next cycle: wr_en_out=1, wr_addr_out={~rd_bank_out, ray_address_in}, wr_data_out=ray_pixel_in. Write latency is exactly 1 cycle.
  - If ray_address_in >= FB_DEPTH: no write (wr_en_out=0), addr_error_out set.
  - ray_valid_in && ray_last_pixel_in: write as normal, then next state WAIT_SWAP.
  - frame_start_in: frames_missed_out increments, saturating at 255. No swap.
- WAIT_SWAP:
  - wr_en_out=0.
  - ray_valid_in is ignored and sets addr_error_out.
  - On frame_start_in: rd_bank_out toggles next cycle, then next state LAUNCH.
- Simultaneous last pixel and frame_start_in in RENDER:
  - frames_missed_out increments.
  - The final write goes to the old back bank.
  - The swap waits for the next frame_start_in, so the front bank is never written while displayed.
- ray_valid_in in LAUNCH: ignored, sets addr_error_out.
- wr_addr_out MSB always equals the complement of rd_bank_out whenever wr_en_out=1.
- frames_missed_out and addr_error_out clear only on reset.

Decomposition:
- Shared package (raycast_pkg):
  - t_sched_state enum {LAUNCH, RENDER, WAIT_SWAP}.
  - FB_DEPTH localparam.
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults.
- No sub-module required. A small sat_counter (width param, inc, clear) is natural if other blocks also need one.

Test Plan:
- Reset then idle: sweep_start_out pulses in cycle 1 after reset, and never again without frame_start_in.
- Full sweep: stream 57600 valid pixels (address = index, pixel = index ^ 16'hA5A5, last on final) -> 57600 writes, each 1 cycle late, all with wr_addr_out[16]=1; state WAIT_SWAP. Then frame_start_in -> rd_bank_out=1 next cycle; sweep_start_out 1 cycle later; next sweep writes with MSB=0.
- Address 57600 and 65535 during RENDER -> no wr_en_out, addr_error_out=1. Valid address 57599 still writes.
- Two frame_start_in pulses during one sweep -> frames_missed_out=2, rd_bank_out unchanged. Apply 300 pulses -> saturates at 255.
- Last pixel and frame_start_in in the same cycle -> last write lands in bank 1, frames_missed_out+1, no swap. The next frame_start_in swaps.
- rst_in asserted mid-RENDER (after 1000 pixels) -> all outputs at reset values next cycle. Fresh sweep_start_out follows; writes target bank 1.
